axi2mem_tcdm_wr_if: RTL and testbench



---
 rtl/axi2mem_pkg.sv | 19 +
 rtl/axi2mem_buffer.sv | 63 ++++++
 rtl/axi2mem_tcdm_wr_if.sv | 188 ++++++++++++++++++
 tb/tb_axi2mem_tcdm_wr_if.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi2mem_pkg.sv
// axi2mem_pkg: shared types and constants for the axi2mem bridge.
package axi2mem_pkg;

    localparam int AXI_ID_WIDTH    = 6;
    localparam int TCDM_DATA_WIDTH = 32;

    // Outstanding write command entry: the burst id and whether the beat closes the burst
    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0] id;
        logic                    last;
    } wr_cmd_t;

    // Write response FSM states
    typedef enum logic {
        RUN     = 1'b0,
        STALLED = 1'b1
    } wr_state_e;

endpackage

// File: rtl/axi2mem_buffer.sv
// axi2mem_buffer: small valid/ready FIFO used for outstanding command tracking.
// Push and pop may happen in the same cycle; ready_o depends only on occupancy.
module axi2mem_buffer #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  ready_i
);

    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  push;
    logic                  pop;

    assign ready_o = (count_q != FULL_CNT);
    assign valid_o = (count_q != '0);
    assign data_o  = mem[rd_ptr_q];
    assign push    = valid_i & ready_o;
    assign pop     = valid_o & ready_i;

    // Pointer and occupancy bookkeeping; pointers wrap explicitly for any depth
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted as valid
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/axi2mem_tcdm_wr_if.sv
// axi2mem_tcdm_wr_if: write-side TCDM interface of the axi2mem bridge.
// Pairs a write command with a data beat, issues one 32-bit TCDM store per
// beat and returns one B-channel response (id) per beat flagged last.
// Build macro AXI2MEM_WR_ACK_EN: when defined, responses wait for the TCDM
// write acknowledge (tcdm_r_valid_i) through an {id,last} queue; when
// undefined, the response is issued in the grant cycle of the last beat.
module axi2mem_tcdm_wr_if
    import axi2mem_pkg::*;
#(
    parameter int CMD_QUEUE_DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       trans_last_i,
    input  logic [AXI_ID_WIDTH-1:0]    trans_id_i,
    input  logic [31:0]                trans_add_i,
    input  logic                       trans_req_i,
    output logic                       trans_gnt_o,
    input  logic [TCDM_DATA_WIDTH-1:0] data_dat_i,
    input  logic [3:0]                 data_strb_i,
    input  logic                       data_req_i,
    output logic                       data_gnt_o,
    output logic [AXI_ID_WIDTH-1:0]    resp_id_o,
    output logic                       resp_req_o,
    input  logic                       resp_gnt_i,
    output logic                       tcdm_req_o,
    output logic [31:0]                tcdm_add_o,
    output logic                       tcdm_we_o,
    output logic [TCDM_DATA_WIDTH-1:0] tcdm_wdata_o,
    output logic [3:0]                 tcdm_be_o,
    input  logic                       tcdm_gnt_i,
    input  logic [TCDM_DATA_WIDTH-1:0] tcdm_r_rdata_i,
    input  logic                       tcdm_r_valid_i
);

    wr_state_e               state_q;
    wr_state_e               state_d;
    logic                    stalled;
    logic                    queue_ready;
    logic                    tcdm_req;
    logic                    tcdm_fire;
    logic                    resp_req;
    logic [AXI_ID_WIDTH-1:0] resp_id;

    // A store needs both operands, no pending response stall and room to
    // track it. Request-side outputs are forced idle while reset is held so
    // upstream FIFOs that are still presenting data see no grant.
    assign tcdm_req     = rst_ni & trans_req_i & data_req_i & ~stalled & queue_ready;
    assign tcdm_fire    = tcdm_req & tcdm_gnt_i;

    assign tcdm_req_o   = tcdm_req;
    assign tcdm_we_o    = ~rst_ni;
    assign tcdm_add_o   = rst_ni ? trans_add_i : '0;
    assign tcdm_wdata_o = rst_ni ? data_dat_i  : '0;
    assign tcdm_be_o    = rst_ni ? data_strb_i : '0;

    assign trans_gnt_o  = tcdm_fire;
    assign data_gnt_o   = tcdm_fire;

    assign resp_req_o   = resp_req;
    assign resp_id_o    = resp_id;

    // Response FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef AXI2MEM_WR_ACK_EN

    wr_cmd_t push_cmd;
    wr_cmd_t head_cmd;
    logic    head_valid;
    logic    ack;
    logic    queue_pop;
    logic    unused_rdata;

    assign push_cmd     = '{id: trans_id_i, last: trans_last_i};
    assign ack          = tcdm_r_valid_i & head_valid;
    assign unused_rdata = ^tcdm_r_rdata_i;

    // An unaccepted response on a last acknowledge blocks the request in the
    // same cycle, so nothing new is ever in flight while STALLED.
    assign stalled = (state_q == STALLED) |
                     ((state_q == RUN) & ack & head_cmd.last & ~resp_gnt_i);

    axi2mem_buffer #(
        .DATA_WIDTH   ($bits(wr_cmd_t)),
        .BUFFER_DEPTH (CMD_QUEUE_DEPTH)
    ) i_cmd_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (tcdm_fire),
        .data_i  (push_cmd),
        .ready_o (queue_ready),
        .valid_o (head_valid),
        .data_o  (head_cmd),
        .ready_i (queue_pop)
    );

    // Response FSM: retire acknowledged beats, respond on the last one
    always_comb begin
        state_d   = state_q;
        resp_req  = 1'b0;
        resp_id   = '0;
        queue_pop = 1'b0;
        case (state_q)
            RUN: begin
                if (ack) begin
                    if (!head_cmd.last) begin
                        queue_pop = 1'b1;
                    end else begin
                        resp_req = 1'b1;
                        resp_id  = head_cmd.id;
                        if (resp_gnt_i) begin
                            queue_pop = 1'b1;
                        end else begin
                            state_d = STALLED;
                        end
                    end
                end
            end
            STALLED: begin
                resp_req = 1'b1;
                resp_id  = head_cmd.id;
                if (resp_gnt_i) begin
                    queue_pop = 1'b1;
                    state_d   = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

`else

    localparam int unused_queue_depth = CMD_QUEUE_DEPTH;

    logic [AXI_ID_WIDTH-1:0] held_id_q;
    logic                    unused_ack;

    // Without acknowledge tracking nothing limits the number in flight
    assign queue_ready = 1'b1;
    assign unused_ack  = ^{tcdm_r_rdata_i, tcdm_r_valid_i};

    // The grant cycle's own store is already committed; the stall only
    // blocks subsequent requests, which avoids a grant -> stall -> request loop.
    assign stalled = (state_q == STALLED);

    // Hold the id of a last beat whose response was refused in its grant cycle
    always_ff @(posedge clk_i) begin
        if ((state_q == RUN) && (state_d == STALLED)) begin
            held_id_q <= trans_id_i;
        end
    end

    // Response FSM: respond in the grant cycle of a last beat, hold if refused
    always_comb begin
        state_d  = state_q;
        resp_req = 1'b0;
        resp_id  = '0;
        case (state_q)
            RUN: begin
                if (tcdm_fire && trans_last_i) begin
                    resp_req = 1'b1;
                    resp_id  = trans_id_i;
                    if (!resp_gnt_i) begin
                        state_d = STALLED;
                    end
                end
            end
            STALLED: begin
                resp_req = 1'b1;
                resp_id  = held_id_q;
                if (resp_gnt_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

`endif

endmodule

// File: tb/tb_axi2mem_tcdm_wr_if.sv
// Testbench for axi2mem_tcdm_wr_if: scoreboard of expected stores and
// responses, filled as beats are driven and drained as the DUT produces them.
module tb_axi2mem_tcdm_wr_if;

`ifdef AXI2MEM_WR_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        trans_last_i = 1'b0;
    logic [5:0]  trans_id_i = '0;
    logic [31:0] trans_add_i = '0;
    logic        trans_req_i = 1'b0;
    logic        trans_gnt_o;
    logic [31:0] data_dat_i = '0;
    logic [3:0]  data_strb_i = '0;
    logic        data_req_i = 1'b0;
    logic        data_gnt_o;
    logic [5:0]  resp_id_o;
    logic        resp_req_o;
    logic        resp_gnt_i = 1'b0;
    logic        tcdm_req_o;
    logic [31:0] tcdm_add_o;
    logic        tcdm_we_o;
    logic [31:0] tcdm_wdata_o;
    logic [3:0]  tcdm_be_o;
    logic        tcdm_gnt_i = 1'b0;
    logic [31:0] tcdm_r_rdata_i = '0;
    logic        tcdm_r_valid_i = 1'b0;

    always #5 clk_i = ~clk_i;

    axi2mem_tcdm_wr_if #(.CMD_QUEUE_DEPTH(2)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .trans_last_i   (trans_last_i),
        .trans_id_i     (trans_id_i),
        .trans_add_i    (trans_add_i),
        .trans_req_i    (trans_req_i),
        .trans_gnt_o    (trans_gnt_o),
        .data_dat_i     (data_dat_i),
        .data_strb_i    (data_strb_i),
        .data_req_i     (data_req_i),
        .data_gnt_o     (data_gnt_o),
        .resp_id_o      (resp_id_o),
        .resp_req_o     (resp_req_o),
        .resp_gnt_i     (resp_gnt_i),
        .tcdm_req_o     (tcdm_req_o),
        .tcdm_add_o     (tcdm_add_o),
        .tcdm_we_o      (tcdm_we_o),
        .tcdm_wdata_o   (tcdm_wdata_o),
        .tcdm_be_o      (tcdm_be_o),
        .tcdm_gnt_i     (tcdm_gnt_i),
        .tcdm_r_rdata_i (tcdm_r_rdata_i),
        .tcdm_r_valid_i (tcdm_r_valid_i)
    );

    typedef struct packed {
        logic [31:0] add;
        logic [31:0] dat;
        logic [3:0]  be;
    } store_t;

    store_t     sb_store[$];
    logic [5:0] sb_resp[$];

    int n_checks = 0;
    int n_fail   = 0;
    bit rv_noise = 1'b0;

    logic       s_req, s_fire, s_tgnt, s_dgnt, s_resp_req;
    logic [5:0] s_resp_id;
    logic       hold_pend = 1'b0;
    logic [5:0] hold_id = '0;

    // One clock: sample at the falling edge, score outputs, then model the
    // TCDM write acknowledge one cycle after each grant.
    task automatic step();
        store_t     exp_s;
        logic [5:0] exp_id;
        @(negedge clk_i);
        s_req      = tcdm_req_o;
        s_fire     = tcdm_req_o & tcdm_gnt_i;
        s_tgnt     = trans_gnt_o;
        s_dgnt     = data_gnt_o;
        s_resp_req = resp_req_o;
        s_resp_id  = resp_id_o;

        if (hold_pend) begin
            n_checks++;
            if (resp_req_o !== 1'b1 || resp_id_o !== hold_id) begin
                n_fail++;
                $display("FAIL resp_hold: req=%b id=%h, required req=1 id=%h", resp_req_o, resp_id_o, hold_id);
            end
        end

        n_checks++;
        if (trans_gnt_o !== s_fire || data_gnt_o !== s_fire) begin
            n_fail++;
            $display("FAIL gnt_pair: trans_gnt=%b data_gnt=%b, required %b", trans_gnt_o, data_gnt_o, s_fire);
        end

        if (s_fire === 1'b1) begin
            n_checks++;
            if (sb_store.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_store: add=%h, required no store", tcdm_add_o);
            end else begin
                exp_s = sb_store.pop_front();
                if ({tcdm_add_o, tcdm_wdata_o, tcdm_be_o, tcdm_we_o} !== {exp_s, 1'b0}) begin
                    n_fail++;
                    $display("FAIL store: add=%h dat=%h be=%h we=%b, required add=%h dat=%h be=%h we=0",
                             tcdm_add_o, tcdm_wdata_o, tcdm_be_o, tcdm_we_o, exp_s.add, exp_s.dat, exp_s.be);
                end
            end
        end

        if (resp_req_o === 1'b1 && resp_gnt_i === 1'b1) begin
            n_checks++;
            if (sb_resp.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_resp: id=%h, required no response", resp_id_o);
            end else begin
                exp_id = sb_resp.pop_front();
                if (resp_id_o !== exp_id) begin
                    n_fail++;
                    $display("FAIL resp_id: id=%h, required %h", resp_id_o, exp_id);
                end
            end
        end

        if (resp_req_o !== 1'b1) begin
            n_checks++;
            if (resp_id_o !== 6'd0) begin
                n_fail++;
                $display("FAIL resp_idle_id: id=%h, required 00", resp_id_o);
            end
        end

        hold_pend = (rst_ni === 1'b1) && (resp_req_o === 1'b1) && (resp_gnt_i === 1'b0);
        hold_id   = resp_id_o;

        @(posedge clk_i);
        #1;
        tcdm_r_valid_i = rv_noise ? 1'($urandom_range(0, 1)) : s_fire;
    endtask

    task automatic drive_beat(input logic [31:0] add, input logic [31:0] dat, input logic [3:0] be,
                              input logic [5:0] id, input logic last, input bit expect_it);
        trans_add_i  = add;
        data_dat_i   = dat;
        data_strb_i  = be;
        trans_id_i   = id;
        trans_last_i = last;
        trans_req_i  = 1'b1;
        data_req_i   = 1'b1;
        if (expect_it) begin
            sb_store.push_back({add, dat, be});
            if (last) sb_resp.push_back(id);
        end
    endtask

    task automatic idle_inputs();
        trans_req_i  = 1'b0;
        data_req_i   = 1'b0;
        trans_last_i = 1'b0;
        trans_id_i   = '0;
        trans_add_i  = '0;
        data_dat_i   = '0;
        data_strb_i  = '0;
    endtask

    task automatic test_reset();
        drive_beat(32'h0000_0100, 32'h1111_2222, 4'hF, 6'd9, 1'b1, 1'b0);
        tcdm_gnt_i = 1'b1;
        resp_gnt_i = 1'b1;
        #2;
        n_checks++;
        if ({tcdm_req_o, tcdm_we_o, trans_gnt_o, data_gnt_o} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_req: req=%b we=%b tgnt=%b dgnt=%b, required 0 1 0 0",
                     tcdm_req_o, tcdm_we_o, trans_gnt_o, data_gnt_o);
        end
        n_checks++;
        if ({tcdm_add_o, tcdm_wdata_o, tcdm_be_o} !== 68'd0) begin
            n_fail++;
            $display("FAIL reset_bus: add=%h dat=%h be=%h, required 0", tcdm_add_o, tcdm_wdata_o, tcdm_be_o);
        end
        n_checks++;
        if (resp_req_o !== 1'b0 || resp_id_o !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_resp: req=%b id=%h, required 0 00", resp_req_o, resp_id_o);
        end
        idle_inputs();
        tcdm_gnt_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_single_write();
        tcdm_gnt_i = 1'b1;
        resp_gnt_i = 1'b1;
        drive_beat(32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 6'd5, 1'b1, 1'b1);
        step();
        n_checks++;
        if (s_fire !== 1'b1) begin
            n_fail++;
            $display("FAIL single_fire: fire=%b, required 1", s_fire);
        end
        n_checks++;
        if (s_resp_req !== ~ACK || s_resp_id !== (ACK ? 6'd0 : 6'd5)) begin
            n_fail++;
            $display("FAIL single_resp_grant_cycle: req=%b id=%h, required %b %h",
                     s_resp_req, s_resp_id, ~ACK, (ACK ? 6'd0 : 6'd5));
        end
        idle_inputs();
        step();
        n_checks++;
        if (s_resp_req !== ACK || s_resp_id !== (ACK ? 6'd5 : 6'd0) || s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resp_next_cycle: req=%b id=%h tcdm_req=%b, required %b %h 0",
                     s_resp_req, s_resp_id, s_req, ACK, (ACK ? 6'd5 : 6'd0));
        end
        step();
        n_checks++;
        if (s_resp_req !== 1'b0) begin
            n_fail++;
            $display("FAIL single_resp_done: req=%b, required 0", s_resp_req);
        end
    endtask

    task automatic test_burst();
        int resp_cnt = 0;
        int resp_at  = -1;
        int fires    = 0;
        tcdm_gnt_i = 1'b1;
        resp_gnt_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) drive_beat(32'(32'h200 + 4 * i), $urandom, 4'hF, 6'h2A, 1'(i == 3), 1'b1);
            else       idle_inputs();
            step();
            if (s_fire === 1'b1) fires++;
            if (s_resp_req === 1'b1) begin
                resp_cnt++;
                resp_at = i;
            end
        end
        n_checks++;
        if (fires != 4) begin
            n_fail++;
            $display("FAIL burst_stores: got %0d, required 4", fires);
        end
        n_checks++;
        if (resp_cnt != 1 || resp_at != (ACK ? 4 : 3)) begin
            n_fail++;
            $display("FAIL burst_resp: count=%0d cycle=%0d, required 1 at %0d", resp_cnt, resp_at, (ACK ? 4 : 3));
        end
    endtask

    task automatic test_backpressure();
        tcdm_gnt_i = 1'b1;
        resp_gnt_i = 1'b0;
        drive_beat(32'h0000_0300, 32'h1234_5678, 4'h3, 6'h11, 1'b1, 1'b1);
        step();
        n_checks++;
        if (s_fire !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first_fire: fire=%b, required 1", s_fire);
        end
        drive_beat(32'h0000_0304, 32'hCAFE_F00D, 4'hC, 6'h12, 1'b1, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            if (k == 4) resp_gnt_i = 1'b1;
            step();
            n_checks++;
            if (s_req !== 1'b0 || s_resp_req !== 1'b1 || s_resp_id !== 6'h11) begin
                n_fail++;
                $display("FAIL bp_stall_%0d: tcdm_req=%b resp_req=%b id=%h, required 0 1 11",
                         k, s_req, s_resp_req, s_resp_id);
            end
        end
        step();
        n_checks++;
        if (s_fire !== 1'b1 || s_resp_req !== ~ACK) begin
            n_fail++;
            $display("FAIL bp_resume: fire=%b resp_req=%b, required 1 %b", s_fire, s_resp_req, ~ACK);
        end
        idle_inputs();
        repeat (2) step();
    endtask

    task automatic test_missing_operand();
        tcdm_gnt_i = 1'b1;
        resp_gnt_i = 1'b1;
        drive_beat(32'h0000_0400, 32'h0BAD_F00D, 4'h1, 6'h07, 1'b1, 1'b1);
        data_req_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (s_req !== 1'b0 || s_tgnt !== 1'b0 || s_dgnt !== 1'b0) begin
                n_fail++;
                $display("FAIL no_data_%0d: req=%b tgnt=%b dgnt=%b, required 0 0 0", k, s_req, s_tgnt, s_dgnt);
            end
        end
        data_req_i = 1'b1;
        tcdm_gnt_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if (s_req !== 1'b1 || s_tgnt !== 1'b0 || s_dgnt !== 1'b0) begin
                n_fail++;
                $display("FAIL no_tcdm_gnt_%0d: req=%b tgnt=%b dgnt=%b, required 1 0 0", k, s_req, s_tgnt, s_dgnt);
            end
        end
        tcdm_gnt_i = 1'b1;
        step();
        n_checks++;
        if (s_tgnt !== 1'b1 || s_dgnt !== 1'b1) begin
            n_fail++;
            $display("FAIL gnt_on_tcdm_gnt: tgnt=%b dgnt=%b, required 1 1", s_tgnt, s_dgnt);
        end
        idle_inputs();
        repeat (2) step();
    endtask

    task automatic test_reset_mid_burst();
        int resp_cnt = 0;
        tcdm_gnt_i = 1'b1;
        resp_gnt_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_beat(32'(32'h500 + 4 * i), $urandom, 4'hF, 6'h33, 1'b0, 1'b1);
            step();
        end
        drive_beat(32'h0000_0508, 32'h5555_AAAA, 4'hF, 6'h33, 1'b0, 1'b0);
        rst_ni    = 1'b0;
        hold_pend = 1'b0;
        #1;
        n_checks++;
        if ({tcdm_req_o, tcdm_we_o, trans_gnt_o, data_gnt_o, resp_req_o} !== 5'b01000 || resp_id_o !== 6'd0) begin
            n_fail++;
            $display("FAIL midburst_reset: req=%b we=%b tgnt=%b dgnt=%b resp=%b id=%h, required 0 1 0 0 0 00",
                     tcdm_req_o, tcdm_we_o, trans_gnt_o, data_gnt_o, resp_req_o, resp_id_o);
        end
        n_checks++;
        if (tcdm_add_o !== 32'd0) begin
            n_fail++;
            $display("FAIL midburst_reset_add: add=%h, required 0", tcdm_add_o);
        end
        repeat (2) step();
        idle_inputs();
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (s_resp_req === 1'b1) resp_cnt++;
        end
        n_checks++;
        if (resp_cnt != 0) begin
            n_fail++;
            $display("FAIL midburst_no_resp: got %0d responses, required 0", resp_cnt);
        end
        drive_beat(32'h0000_0510, 32'h7777_8888, 4'hF, 6'h3C, 1'b1, 1'b1);
        step();
        idle_inputs();
        resp_cnt = (s_resp_req === 1'b1) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            step();
            if (s_resp_req === 1'b1) resp_cnt++;
        end
        n_checks++;
        if (resp_cnt != 1) begin
            n_fail++;
            $display("FAIL post_reset_resp: got %0d responses, required 1", resp_cnt);
        end
    endtask

`ifndef AXI2MEM_WR_ACK_EN
    task automatic test_ack_ignored();
        int resp_cnt = 0;
        rv_noise   = 1'b1;
        tcdm_gnt_i = 1'b1;
        resp_gnt_i = 1'b1;
        drive_beat(32'h0000_0600, 32'h0F0F_0F0F, 4'hA, 6'h15, 1'b0, 1'b1);
        step();
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            step();
            if (s_resp_req === 1'b1) resp_cnt++;
        end
        n_checks++;
        if (resp_cnt != 0) begin
            n_fail++;
            $display("FAIL noack_spurious: got %0d responses, required 0", resp_cnt);
        end
        drive_beat(32'h0000_0604, 32'hF0F0_F0F0, 4'h5, 6'h15, 1'b1, 1'b1);
        step();
        n_checks++;
        if (s_fire !== 1'b1 || s_resp_req !== 1'b1 || s_resp_id !== 6'h15) begin
            n_fail++;
            $display("FAIL noack_grant_resp: fire=%b req=%b id=%h, required 1 1 15", s_fire, s_resp_req, s_resp_id);
        end
        idle_inputs();
        resp_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (s_resp_req === 1'b1) resp_cnt++;
        end
        n_checks++;
        if (resp_cnt != 0) begin
            n_fail++;
            $display("FAIL noack_after: got %0d responses, required 0", resp_cnt);
        end
        rv_noise = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_burst();
        test_backpressure();
        test_missing_operand();
        test_reset_mid_burst();
`ifndef AXI2MEM_WR_ACK_EN
        test_ack_ignored();
`endif
        n_checks++;
        if (sb_store.size() != 0) begin
            n_fail++;
            $display("FAIL store_drain: %0d stores outstanding, required 0", sb_store.size());
        end
        n_checks++;
        if (sb_resp.size() != 0) begin
            n_fail++;
            $display("FAIL resp_drain: %0d responses outstanding, required 0", sb_resp.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
